// File: rtl/criscv_pkg.sv
// Shared criscv decode constants.
// Opcodes and funct3 encodings for the RV32I integer ALU.
package criscv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/rv32_alu.sv
// Registered RV32I integer ALU for OP and OP-IMM.
// One clk strobe per instruction captures the result.
module rv32_alu
  import criscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        modbit,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] rd,
  output logic        comp
);

  logic        is_imm;
  logic        is_op;
  logic        valid;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] sra_res;
  logic [31:0] next_rd;

  assign is_imm  = (opcode == OPC_OP_IMM);
  assign is_op   = (opcode == OPC_OP);
  assign valid   = is_imm | is_op;
  assign op_b    = is_imm ? imm : rs2;
  assign shamt   = op_b[4:0];
  assign sra_res = $signed(rs1) >>> shamt;

  // imm[10] aliases modbit on OP-IMM, so only OP may subtract
  always_comb begin
    next_rd = '0;
    unique case (funct3)
      F3_ADD:  next_rd = (is_op && modbit) ? rs1 - op_b
                                           : rs1 + op_b;
      F3_SLL:  next_rd = rs1 << shamt;
      F3_SLT:  next_rd = {31'b0,
                          $signed(rs1) < $signed(op_b)};
      F3_SLTU: next_rd = {31'b0, rs1 < op_b};
      F3_XOR:  next_rd = rs1 ^ op_b;
      F3_SR:   next_rd = modbit ? sra_res : rs1 >> shamt;
      F3_OR:   next_rd = rs1 | op_b;
      F3_AND:  next_rd = rs1 & op_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd   <= '0;
      comp <= 1'b0;
    end else begin
      comp <= valid;
      if (valid) rd <= next_rd;
    end
  end

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu.
// Directed table, reset corners, and randomized model checks.
module tb_rv32_alu;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam longint MOD = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        modbit = 1'b0;
  logic [31:0] imm = '0;
  logic [6:0]  opcode = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] rd;
  logic        comp;

  int n_checks = 0;
  int n_fail = 0;

  rv32_alu dut (
    .clk(clk), .reset(reset), .funct3(funct3),
    .modbit(modbit), .imm(imm), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rd(rd), .comp(comp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        mb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] exp_rd;
    logic        exp_comp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic strobe(input logic [6:0] o,
                        input logic [2:0] f,
                        input logic m,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] i);
    @(negedge clk);
    opcode = o; funct3 = f; modbit = m;
    rs1 = a; rs2 = b; imm = i;
    @(posedge clk);
    #1;
  endtask

  // Reference computed with integer arithmetic on 64-bit values
  function automatic logic [31:0] model(
      input logic [6:0] o, input logic [2:0] f,
      input logic m, input logic [31:0] a_in,
      input logic [31:0] r2, input logic [31:0] i);
    longint a, b, sa, sb, p, q, r;
    int sh;
    a  = longint'(a_in);
    b  = (o == OPI) ? longint'(i) : longint'(r2);
    sa = (a >= MOD / 2) ? a - MOD : a;
    sb = (b >= MOD / 2) ? b - MOD : b;
    sh = int'(b % 32);
    p  = 64'd1 << sh;
    r  = 0;
    case (f)
      3'd0: r = (o == OPR && m) ? (a - b + MOD) % MOD
                                : (a + b) % MOD;
      3'd1: r = (a * p) % MOD;
      3'd2: r = (sa < sb) ? 1 : 0;
      3'd3: r = (a < b) ? 1 : 0;
      3'd4: r = longint'(a_in ^ b[31:0]);
      3'd5: begin
        if (m) begin
          q = sa / p;
          if (sa < 0 && q * p != sa) q = q - 1;
          r = (q + MOD) % MOD;
        end else r = a / p;
      end
      3'd6: r = longint'(a_in | b[31:0]);
      default: r = longint'(a_in & b[31:0]);
    endcase
    return r[31:0];
  endfunction

  initial begin
    logic [31:0] exp_rd;
    vecs.push_back('{"addi_modbit", OPI, 3'd0, 1'b1,
      32'd10, 32'd0, 32'hFFFFFFFD, 32'd7, 1'b1});
    vecs.push_back('{"sub", OPR, 3'd0, 1'b1,
      32'd5, 32'd7, 32'd0, 32'hFFFFFFFE, 1'b1});
    vecs.push_back('{"srai", OPI, 3'd5, 1'b1,
      32'h80000000, 32'd0, 32'h404, 32'hF8000000, 1'b1});
    vecs.push_back('{"srl", OPR, 3'd5, 1'b0,
      32'h80000000, 32'h24, 32'd0, 32'h08000000, 1'b1});
    vecs.push_back('{"sll", OPR, 3'd1, 1'b0,
      32'd1, 32'd31, 32'd0, 32'h80000000, 1'b1});
    vecs.push_back('{"slt", OPR, 3'd2, 1'b0,
      32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 1'b1});
    vecs.push_back('{"sltu", OPR, 3'd3, 1'b0,
      32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{"sltiu", OPI, 3'd3, 1'b0,
      32'd5, 32'd0, 32'hFFFFFFFF, 32'd1, 1'b1});
    vecs.push_back('{"xor", OPR, 3'd4, 1'b0,
      32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'hFF00FF00, 1'b1});
    vecs.push_back('{"or", OPR, 3'd6, 1'b0,
      32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'hFFF0FFF0, 1'b1});
    vecs.push_back('{"and", OPR, 3'd7, 1'b0,
      32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'h00F000F0, 1'b1});
    vecs.push_back('{"add_wrap", OPR, 3'd0, 1'b0,
      32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{"addi_seven", OPI, 3'd0, 1'b0,
      32'd3, 32'd0, 32'd4, 32'd7, 1'b1});
    vecs.push_back('{"non_alu_hold", LUI, 3'd0, 1'b0,
      32'd100, 32'd200, 32'd300, 32'd7, 1'b0});

    // Power-on reset
    #2;
    check("por_rd", rd, 32'd0);
    check("por_comp", {31'b0, comp}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset with rd = 5, no clk edge
    strobe(OPI, 3'd0, 1'b0, 32'd5, 32'd0, 32'd0);
    check("pre_reset_rd", rd, 32'd5);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_rd", rd, 32'd0);
    check("async_reset_comp", {31'b0, comp}, 32'd0);
    #1;
    reset = 1'b1;

    foreach (vecs[k]) begin
      strobe(vecs[k].opc, vecs[k].f3, vecs[k].mb,
             vecs[k].a, vecs[k].b, vecs[k].im);
      check({vecs[k].name, "_rd"}, rd, vecs[k].exp_rd);
      check({vecs[k].name, "_comp"}, {31'b0, comp},
            {31'b0, vecs[k].exp_comp});
    end

    // Reset coincident with a clk edge carrying a valid op
    @(negedge clk);
    opcode = OPR; funct3 = 3'd6; modbit = 1'b0;
    rs1 = 32'h1234; rs2 = 32'h5678;
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("edge_reset_rd", rd, 32'd0);
    check("edge_reset_comp", {31'b0, comp}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    exp_rd = 32'd0;
    for (int n = 0; n < 300; n++) begin
      logic [6:0]  o;
      logic [2:0]  f;
      logic        m;
      logic [31:0] a, b, i;
      int sel;
      sel = $urandom_range(0, 9);
      o = (sel < 5) ? OPR : (sel < 9) ? OPI
                          : 7'($urandom_range(0, 127));
      f = 3'($urandom_range(0, 7));
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      i = 32'($signed(12'($urandom)));
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      strobe(o, f, m, a, b, i);
      if (o == OPI || o == OPR)
        exp_rd = model(o, f, m, a, b, i);
      check("rand_rd", rd, exp_rd);
      check("rand_comp", {31'b0, comp},
            {31'b0, (o == OPI || o == OPR)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
